// File: rtl/apb_mst_pkg.sv
// Shared types for the APB read/write/read-modify-write master.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package apb_mst_pkg;

  // Bus sequencing state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Command opcodes as presented on cmd_op
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RMW   = 2'b11
  } op_t;

  // Which half of a read-modify-write is on the bus
  typedef enum logic {
    PH_READ  = 1'b0,
    PH_WRITE = 1'b1
  } rmw_phase_t;

endpackage

// File: rtl/apb_mst_tmo_cnt.sv
// ACCESS-phase timeout counter: flags expiry on the CYC-th consecutive stalled cycle.
// Latency: expire is combinational from the count and en, same cycle.
// Backpressure: none; holds its count while en is low, clr wins over en.
module apb_mst_tmo_cnt #(
  parameter int CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (CYC < 2) ? 1 : $clog2(CYC);
  localparam logic [W-1:0] LAST = W'(CYC - 1);

  logic [W-1:0] cnt;

  // Count stalled ACCESS cycles; restart whenever a new SETUP begins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/apb_rmw_mst.sv
// APB master for READ / WRITE / RMW_INC commands; optional ACCESS timeout under APB_MST_TIMEOUT_EN.
// Latency: accept T -> rsp T+3 (RMW_INC T+5), plus one per pready wait cycle; NOP rsp at T+1.
// Backpressure: cmd_ready only in IDLE, so one command in flight; pready stalls ACCESS.
module apb_rmw_mst
  import apb_mst_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int INC_VAL     = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [DATA_W-1:0] INC_D = DATA_W'(INC_VAL);

  state_t      state;
  op_t         op_q;
  rmw_phase_t  phase;
  logic [DATA_W-1:0] orig_q;
  logic        tmo_expire;

  assign cmd_ready = (state == IDLE);

`ifdef APB_MST_TIMEOUT_EN
  apb_mst_tmo_cnt #(
    .CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == SETUP),
    .en     ((state == ACCESS) && !pready),
    .expire (tmo_expire)
  );
`else
  // Without the timeout ACCESS waits on pready for as long as it takes
  logic unused_tmo_cyc;
  assign unused_tmo_cyc = (TIMEOUT_CYC != 0);
  assign tmo_expire     = 1'b0;
`endif

  // Command capture, APB sequencing and single-cycle response generation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      phase     <= PH_READ;
      orig_q    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= op_t'(cmd_op);
            if (op_t'(cmd_op) == OP_NOP) begin
              // Illegal op: answer immediately, never touch the bus
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state   <= SETUP;
              psel    <= 1'b1;
              penable <= 1'b0;
              paddr   <= cmd_addr;
              pwrite  <= (op_t'(cmd_op) == OP_WRITE);
              pwdata  <= (op_t'(cmd_op) == OP_WRITE) ? cmd_wdata : '0;
              phase   <= PH_READ;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            if (op_q == OP_RMW && phase == PH_READ && !pslverr) begin
              // Turn the read around into the incremented write-back
              state   <= SETUP;
              penable <= 1'b0;
              pwrite  <= 1'b1;
              pwdata  <= prdata + INC_D;
              orig_q  <= prdata;
              phase   <= PH_WRITE;
            end else begin
              state     <= IDLE;
              psel      <= 1'b0;
              penable   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_err   <= pslverr;
              if (op_q == OP_WRITE)
                rsp_rdata <= '0;
              else if (op_q == OP_RMW && phase == PH_WRITE)
                rsp_rdata <= orig_q;
              else
                rsp_rdata <= prdata;
            end
          end else if (tmo_expire) begin
            // Slave never answered: abandon the transfer and report an error
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rmw_mst.sv
// Self-checking bench for apb_rmw_mst: directed cases, reset abort, random commands.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_rmw_mst;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs, one set per phase direction
  int          wait_rd = 0, wait_wr = 0;
  logic        err_rd = 1'b0, err_wr = 1'b0;
  logic [31:0] rd_val = 32'h0;
  int          acc_cnt = 0;

  always #5 clk = ~clk;

  apb_rmw_mst #(
    .ADDR_W(32), .DATA_W(32), .INC_VAL(1), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Slave model: ready after the configured number of stalled ACCESS cycles
  assign pready  = psel && penable && (acc_cnt >= (pwrite ? wait_wr : wait_rd));
  assign pslverr = pready && (pwrite ? err_wr : err_rd);
  assign prdata  = rd_val;

  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  // Observations of one command
  logic        obs_got, obs_err, obs_bus_at_rsp, obs_rdy_at_rsp, obs_wr_seen;
  logic [31:0] obs_rdata, obs_wr_dat, obs_paddr;
  int          obs_lat, obs_setups, obs_accs, obs_unstable;
  // Expectations of one command
  logic        exp_err, exp_wr_seen;
  logic [31:0] exp_rdata, exp_wr_dat;
  int          exp_lat, exp_setups, exp_accs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch the bus until its response (bounded)
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    logic [64:0] snap;
    int n;
    snap = '0;
    obs_got = 0; obs_err = 0; obs_rdata = 0; obs_lat = 0; obs_setups = 0; obs_accs = 0;
    obs_unstable = 0; obs_wr_seen = 0; obs_wr_dat = 0; obs_paddr = 0;
    obs_bus_at_rsp = 1; obs_rdy_at_rsp = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
    for (int i = 1; i <= 60 && !obs_got; i++) begin
      @(negedge clk);
      if (psel && !penable) begin
        obs_setups++;
        snap = {paddr, pwrite, pwdata};
        obs_paddr = paddr;
      end
      if (psel && penable) begin
        obs_accs++;
        if ({paddr, pwrite, pwdata} !== snap) obs_unstable++;
        if (pwrite && pready) begin obs_wr_seen = 1; obs_wr_dat = pwdata; end
      end
      if (rsp_valid) begin
        obs_got = 1; obs_lat = i; obs_rdata = rsp_rdata; obs_err = rsp_err;
        obs_bus_at_rsp = psel | penable; obs_rdy_at_rsp = cmd_ready;
      end
    end
  endtask

  // Expected outcome from the command semantics and the slave knobs
  task automatic ref_model(input logic [1:0] op, input logic [31:0] wd);
    exp_wr_seen = 0; exp_wr_dat = 0; exp_rdata = 0;
    case (op)
      2'b00: begin exp_lat = 1; exp_err = 1; exp_setups = 0; exp_accs = 0; end
      2'b01: begin
        exp_lat = 3 + wait_rd; exp_err = err_rd; exp_rdata = rd_val;
        exp_setups = 1; exp_accs = wait_rd + 1;
      end
      2'b10: begin
        exp_lat = 3 + wait_wr; exp_err = err_wr; exp_setups = 1; exp_accs = wait_wr + 1;
        exp_wr_seen = 1; exp_wr_dat = wd;
      end
      default: begin
        exp_rdata = rd_val;
        if (err_rd) begin
          exp_lat = 3 + wait_rd; exp_err = 1; exp_setups = 1; exp_accs = wait_rd + 1;
        end else begin
          exp_lat = 5 + wait_rd + wait_wr; exp_err = err_wr; exp_setups = 2;
          exp_accs = wait_rd + wait_wr + 2;
          exp_wr_seen = 1; exp_wr_dat = rd_val + 32'd1;
        end
      end
    endcase
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] op,
                               input logic [31:0] addr, input logic [31:0] wd);
    ref_model(op, wd);
    run_cmd(op, addr, wd);
    check({tag, ".got"}, obs_got, 1);
    check({tag, ".lat"}, obs_lat, exp_lat);
    check({tag, ".rdata"}, obs_rdata, exp_rdata);
    check({tag, ".err"}, obs_err, exp_err);
    check({tag, ".setups"}, obs_setups, exp_setups);
    check({tag, ".accs"}, obs_accs, exp_accs);
    check({tag, ".stable"}, obs_unstable, 0);
    check({tag, ".wr_seen"}, obs_wr_seen, exp_wr_seen);
    if (exp_wr_seen) check({tag, ".wr_dat"}, obs_wr_dat, exp_wr_dat);
    if (exp_setups > 0) check({tag, ".paddr"}, obs_paddr, addr);
    check({tag, ".bus_idle_at_rsp"}, obs_bus_at_rsp, 0);
    check({tag, ".ready_at_rsp"}, obs_rdy_at_rsp, 1);
  endtask

  initial begin
    int rsp_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_addr, r_wd;
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.psel", psel, 0);
    check("rst.penable", penable, 0);
    check("rst.pwrite", pwrite, 0);
    check("rst.paddr", paddr, 0);
    check("rst.pwdata", pwdata, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_err", rsp_err, 0);
    check("rst.rsp_rdata", rsp_rdata, 0);
    check("rst.cmd_ready", cmd_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // READ, no waits
    rd_val = 32'hDEADCAFE; wait_rd = 0; err_rd = 0;
    run_and_check("read", 2'b01, 32'h10, 32'h0);
    // WRITE, three wait states
    wait_wr = 3; err_wr = 0;
    run_and_check("write_wait", 2'b10, 32'h20, 32'h1234);
    wait_wr = 0;
    // RMW_INC with wrap to zero
    rd_val = 32'hFFFFFFFF;
    run_and_check("rmw_wrap", 2'b11, 32'h30, 32'h0);
    // RMW_INC with error on the read phase
    rd_val = 32'h00000055; err_rd = 1;
    run_and_check("rmw_rderr", 2'b11, 32'h34, 32'h0);
    err_rd = 0;
    // Illegal op
    run_and_check("nop", 2'b00, 32'h44, 32'h0);
    // RMW_INC with waits in both phases and a write-phase error
    rd_val = 32'h7FFFFFFF; wait_rd = 2; wait_wr = 1; err_wr = 1;
    run_and_check("rmw_wrerr", 2'b11, 32'h38, 32'h0);
    wait_rd = 0; wait_wr = 0; err_wr = 0;

`ifdef APB_MST_TIMEOUT_EN
    // Slave never ready: abort after four ACCESS cycles
    wait_rd = 1000; rd_val = 32'h12345678;
    run_cmd(2'b01, 32'h40, 32'h0);
    check("tmo.got", obs_got, 1);
    check("tmo.lat", obs_lat, 6);
    check("tmo.err", obs_err, 1);
    check("tmo.accs", obs_accs, 4);
    check("tmo.bus_idle_at_rsp", obs_bus_at_rsp, 0);
    wait_rd = 0;
`endif

    // Reset asserted during ACCESS drops the bus at once and loses the command
    wait_rd = 10;
    cmd_valid = 1; cmd_op = 2'b01; cmd_addr = 32'h50; cmd_wdata = 0;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = 0;
    repeat (3) @(negedge clk);
    check("rstmid.in_access", psel && penable, 1);
    rst = 1'b0;
    #1;
    check("rstmid.psel", psel, 0);
    check("rstmid.penable", penable, 0);
    @(negedge clk);
    rst = 1'b1;
    rsp_cnt = 0;
    repeat (10) begin @(negedge clk); if (rsp_valid) rsp_cnt++; end
    check("rstmid.no_rsp", rsp_cnt, 0);
    check("rstmid.cmd_ready", cmd_ready, 1);
    wait_rd = 0;

    // Random commands, back to back
    for (int k = 0; k < 30; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_addr = $urandom; r_wd = $urandom; rd_val = $urandom;
      wait_rd = $urandom_range(0, 3); wait_wr = $urandom_range(0, 3);
      err_rd = ($urandom_range(0, 3) == 0); err_wr = ($urandom_range(0, 3) == 0);
      run_and_check($sformatf("rnd%0d", k), r_op, r_addr, r_wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
